secuenciador_rom: RTL
=====================

# secuenciador_rom

Instruction-fetch sequencer for the 256 × 9-bit instruction ROM. It owns the program counter and drives the ROM address. It compensates for the ROM's negedge-registered read and presents each instruction to the decoder with a valid/ready handshake. It also handles jumps and, optionally, a halt state. It sits between the ROM and the decode stage of the microprocessor.

## Interface
Parameters:
- ANCHO_DIR, 8, ROM address width / PC width
- ANCHO_INST, 9, instruction width
- DIR_INICIO, 8'h00, PC value after reset

Ports:
- Clk  in  1  single system clock; all state updates on posedge
- Rst_n  in  1  reset, asynchronous, active-low
- Direccion_Instrucciones  out  ANCHO_DIR  address to ROM (registered PC)
- Instruccion  in  ANCHO_INST  data from ROM (ROM latches address at negedge)
- Instr_Dec  out  ANCHO_INST  instruction to decoder (direct from Instruccion)
- PC_Dec  out  ANCHO_DIR  address of Instr_Dec (equals Direccion_Instrucciones)
- Instr_Valida  out  1  Instr_Dec/PC_Dec valid this cycle
- Listo  in  1  decoder accepts; transfer = Instr_Valida & Listo
- Salto  in  1  jump request, sampled at posedge
- Destino  in  ANCHO_DIR  jump target, valid with Salto
- Halt  in  1  stop fetching (only with FETCH_HALT_EN)
- Detenido  out  1  sequencer halted (only with FETCH_HALT_EN)

## Operation
- States: ARRANQUE, CORRE, VACIADO, DETENIDO.
- Priority at each posedge: Rst_n low > Salto > Halt > transfer > hold.
- ARRANQUE:
  - Entered on reset.
  - Instr_Valida=0.
  - Moves to CORRE after one cycle unless Salto or Halt is asserted.
- CORRE:
  - Instr_Valida=1.
  - On transfer: PC <= PC+1, wrapping mod 2^ANCHO_DIR (FF→00); state stays CORRE.
  - Listo=0: PC held; Instr_Dec stays stable.
- Salto=1 in any state:
  - PC <= Destino; state <= VACIADO.
  - Overrides the increment even if a transfer occurs the same cycle.
  - The decoder owns the consequences of that same-cycle transfer.
- VACIADO:
  - Instr_Valida=0 for exactly one cycle, then CORRE.
  - A new Salto in VACIADO reloads PC and stays in VACIADO one more cycle.
- Halt=1 (not Salto):
  - State <= DETENIDO; PC frozen; Instr_Valida=0; Detenido=1.
  - Exits only via Salto (→VACIADO) or reset. Halt is ignored while already DETENIDO.
- Reset values, applied immediately on Rst_n fall:
  - PC=DIR_INICIO
  - state=ARRANQUE
  - Instr_Valida=0
  - Detenido=0
- Instr_Valida is decoded from the registered state only; it has no combinational path from Listo, Salto or Halt.

## Timing
- The PC updates at posedge k. The ROM captures it at negedge k, so Instruccion=ROM[PC] is stable before posedge k+1.
- Throughput in CORRE: one instruction per cycle.
- Between posedge k and negedge k, Instr_Dec still shows the previous word. Consumers must sample it only at posedge.
- First valid instruction: the second posedge after Rst_n rises. Instr_Valida goes high at the first posedge after release.
- Jump latency: Salto at posedge k → Instr_Valida=0 in cycle k → Instr_Valida=1 with PC_Dec=Destino from posedge k+1.
- Halt latency: Halt at posedge k → Detenido=1 and Instr_Valida=0 from posedge k.

## Configuration
- FETCH_HALT_EN defined:
  - Halt and Detenido ports exist.
  - DETENIDO state is implemented as described.
- FETCH_HALT_EN undefined:
  - Neither port exists; DETENIDO is unreachable and not synthesised.
  - Priority reduces to reset > Salto > transfer > hold.

## Structure
- Shared package micro_pkg holds:
  - state encoding localparams: ARRANQUE=2'd0, CORRE=2'd1, VACIADO=2'd2, DETENIDO=2'd3
  - default widths ANCHO_DIR=8, ANCHO_INST=9
- One sub-module, contador_pc: loadable, enable-gated, wrapping ANCHO_DIR counter with asynchronous active-low reset to DIR_INICIO.
  - Inputs: Carga/Destino for jumps and Inc for transfers.
  - The top level keeps the FSM and handshake logic.

## Test plan
- Reset release with ROM[0..3]=9'h101,9'h002,9'h0F3,9'h1FF, Listo=1:
  - Instr_Valida rises 1 cycle after release.
  - PC_Dec=0,1,2,3 and Instr_Dec=those words on consecutive cycles.
- Listo=0 for 3 cycles at PC=2:
  - Direccion_Instrucciones stays 2; Instr_Dec=9'h0F3 and Instr_Valida=1 throughout.
  - Resumes with 3 after Listo returns.
- Salto with Destino=8'hFE, then Listo=1:
  - One invalid cycle, then PC_Dec=FE, FF, 00, 01 (wrap-around).
- Salto with Destino=8'h40 during a transfer at PC=5:
  - PC becomes 40, not 6; Instr_Valida=0 for one cycle; next valid PC_Dec=40.
  - A back-to-back Salto (Destino=8'h50) in VACIADO gives one more invalid cycle, then 50.
- (FETCH_HALT_EN) Halt at PC=7:
  - Detenido=1 and Instr_Valida=0 from the next posedge; address stays 7 for 10 cycles.
  - Salto with Destino=8'h10 then gives Detenido=0, one invalid cycle, then PC_Dec=10.
- Rst_n pulled low mid-cycle at PC=8'h33:
  - PC=00, Instr_Valida=0 and Detenido=0 before the next posedge.
  - Normal start-up sequence after release.

Source files
------------

// File: rtl/micro_pkg.sv
// -----------------------------------------------------------------------------
// micro_pkg
// Shared definitions for the microprocessor front end: default widths and the
// instruction-fetch sequencer state encoding.
// No ports.
// -----------------------------------------------------------------------------
package micro_pkg;

    localparam int ANCHO_DIR  = 8;
    localparam int ANCHO_INST = 9;

    typedef enum logic [1:0] {
        ARRANQUE = 2'd0,
        CORRE    = 2'd1,
        VACIADO  = 2'd2,
        DETENIDO = 2'd3
    } estado_t;

endpackage

// File: rtl/secuenciador_rom_if.sv
// -----------------------------------------------------------------------------
// secuenciador_rom_if
// Fetch-to-decode handshake bundle.
//   Instr_Dec    : instruction word presented to the decoder
//   PC_Dec       : address of Instr_Dec
//   Instr_Valida : Instr_Dec/PC_Dec valid this cycle
//   Listo        : decoder accepts (transfer = Instr_Valida & Listo)
// Modports: master = sequencer, slave = decoder.
// -----------------------------------------------------------------------------
interface secuenciador_rom_if #(
    parameter int ANCHO_DIR  = micro_pkg::ANCHO_DIR,
    parameter int ANCHO_INST = micro_pkg::ANCHO_INST
);
    logic [ANCHO_INST-1:0] Instr_Dec;
    logic [ANCHO_DIR-1:0]  PC_Dec;
    logic                  Instr_Valida;
    logic                  Listo;

    modport master (
        output Instr_Dec,
        output PC_Dec,
        output Instr_Valida,
        input  Listo
    );

    modport slave (
        input  Instr_Dec,
        input  PC_Dec,
        input  Instr_Valida,
        output Listo
    );
endinterface

// File: rtl/secuenciador_rom_contador_pc.sv
// -----------------------------------------------------------------------------
// contador_pc
// Program counter: loadable, enable-gated, wraps modulo 2^ANCHO_DIR.
//   Clk     : system clock
//   Rst_n   : async active-low reset, loads DIR_INICIO
//   Carga   : load Destino (takes priority over Inc)
//   Destino : load value
//   Inc     : increment by one
//   Pc      : current count
// -----------------------------------------------------------------------------
module contador_pc #(
    parameter int                   ANCHO_DIR  = micro_pkg::ANCHO_DIR,
    parameter logic [ANCHO_DIR-1:0] DIR_INICIO = '0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Carga,
    input  logic [ANCHO_DIR-1:0] Destino,
    input  logic                 Inc,
    output logic [ANCHO_DIR-1:0] Pc
);

    logic [ANCHO_DIR-1:0] pc_q;
    logic [ANCHO_DIR-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (Carga) begin
            pc_d = Destino;
        end else if (Inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q <= DIR_INICIO;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign Pc = pc_q;

endmodule

// File: rtl/secuenciador_rom.sv
// -----------------------------------------------------------------------------
// secuenciador_rom
// Instruction-fetch sequencer for the instruction ROM. Owns the PC, drives the
// ROM address and hands each word to the decoder over a valid/ready bundle.
// The ROM registers its address on negedge, so the word for the PC updated at
// posedge k is stable before posedge k+1; Instr_Dec is passed straight through.
//
// Ports:
//   Clk, Rst_n              : clock, async active-low reset
//   Direccion_Instrucciones : ROM address (registered PC)
//   Instruccion             : ROM data
//   Salto, Destino          : jump request and target
//   Halt, Detenido          : halt request / halted flag (FETCH_HALT_EN only)
//   dec                     : decoder handshake (master side)
//
// Optional feature macro: FETCH_HALT_EN (adds Halt/Detenido and DETENIDO).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARRANQUE | first cycle after reset, ROM word not yet valid
// CORRE    | streaming, one word per accepted transfer
// VACIADO  | one bubble after a jump while ROM fetches the target
// DETENIDO | halted, PC frozen, leaves only via Salto or reset
// -----------------------------------------------------------------------------
module secuenciador_rom #(
    parameter int                   ANCHO_DIR  = micro_pkg::ANCHO_DIR,
    parameter int                   ANCHO_INST = micro_pkg::ANCHO_INST,
    parameter logic [ANCHO_DIR-1:0] DIR_INICIO = '0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    output logic [ANCHO_DIR-1:0]  Direccion_Instrucciones,
    input  logic [ANCHO_INST-1:0] Instruccion,
    input  logic                  Salto,
    input  logic [ANCHO_DIR-1:0]  Destino,
`ifdef FETCH_HALT_EN
    input  logic                  Halt,
    output logic                  Detenido,
`endif
    secuenciador_rom_if.master    dec
);
    import micro_pkg::*;

    estado_t              estado_q;
    estado_t              estado_d;
    logic                 carga;
    logic                 inc;
    logic                 transfer;
    logic [ANCHO_DIR-1:0] pc;

    contador_pc #(
        .ANCHO_DIR  (ANCHO_DIR),
        .DIR_INICIO (DIR_INICIO)
    ) u_contador_pc (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Carga   (carga),
        .Destino (Destino),
        .Inc     (inc),
        .Pc      (pc)
    );

    // Valid comes only from the registered state, never from inputs.
    assign dec.Instr_Valida = (estado_q == CORRE);
    assign transfer         = dec.Instr_Valida & dec.Listo;

    always_comb begin
        estado_d = estado_q;
        carga    = 1'b0;
        inc      = 1'b0;
        if (Salto) begin
            // A jump wins even over a same-cycle transfer.
            carga    = 1'b1;
            estado_d = VACIADO;
        end
`ifdef FETCH_HALT_EN
        else if (Halt) begin
            estado_d = DETENIDO;
        end
`endif
        else begin
            case (estado_q)
                ARRANQUE: estado_d = CORRE;
                CORRE:    inc      = transfer;
                VACIADO:  estado_d = CORRE;
                default: begin
`ifdef FETCH_HALT_EN
                    estado_d = DETENIDO;
`else
                    estado_d = ARRANQUE;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            estado_q <= ARRANQUE;
        end else begin
            estado_q <= estado_d;
        end
    end

    assign Direccion_Instrucciones = pc;
    assign dec.PC_Dec              = pc;
    assign dec.Instr_Dec           = Instruccion;

`ifdef FETCH_HALT_EN
    assign Detenido = (estado_q == DETENIDO);
`endif

endmodule
